// File: rtl/rtc_disp_scan_if.sv
// ---------------------------------------------------------------------------
// rtc_disp_scan_if
// Bundle of the signals exchanged between the clock core / board side and the
// multiplexed 7-segment display driver.
//
// Signals
//   en      scan enable (core -> driver)
//   tick    one-cycle pulse per second, toggles the colon (core -> driver)
//   s_l .. h_m  six 7-bit active-high segment codes (core -> driver)
//   seg     shared segment bus (driver -> pins)
//   dp      colon / decimal-point segment (driver -> pins)
//   an      active-low one-hot digit enables (driver -> pins)
//   frame   one-cycle pulse at the start of each scan (driver -> core)
//
// Modports
//   master  the side that supplies codes and observes the pins
//   slave   the display driver itself
// ---------------------------------------------------------------------------
interface rtc_disp_scan_if;
   logic       en;
   logic       tick;
   logic [6:0] s_l;
   logic [6:0] s_m;
   logic [6:0] m_l;
   logic [6:0] m_m;
   logic [6:0] h_l;
   logic [6:0] h_m;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frame;

   modport master (
      output en, tick, s_l, s_m, m_l, m_m, h_l, h_m,
      input  seg, dp, an, frame
   );

   modport slave (
      input  en, tick, s_l, s_m, m_l, m_m, h_l, h_m,
      output seg, dp, an, frame
   );
endinterface

// File: rtl/rtc_disp_scan.sv
// ---------------------------------------------------------------------------
// rtc_disp_scan
// Time-multiplexed driver for six 7-segment digits of the real-time clock.
// Each digit gets a slot of DIV cycles; the first BLANK cycles of every slot
// are blanked to avoid ghosting. All six codes are captured together at the
// start of a scan so one frame always shows a single consistent time.
//
// Parameters
//   DIV          clock cycles per digit slot (2 .. 2^20)
//   BLANK        blank cycles at the start of each slot (1 .. DIV-1)
//   SEG_ACT_LOW  invert seg and dp at the output register when 1
//
// Ports
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     rtc_disp_scan_if.slave: en, tick, six codes in; seg, dp, an,
//           frame out (all outputs registered, one cycle after the state)
// ---------------------------------------------------------------------------
module rtc_disp_scan #(
   parameter int DIV         = 50000,
   parameter int BLANK       = 500,
   parameter bit SEG_ACT_LOW = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   rtc_disp_scan_if.slave bus
);

   localparam int             CW        = $clog2(DIV);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0]  BLANK_END = CW'(BLANK);
   localparam logic [6:0]     SEG_POL   = {7{SEG_ACT_LOW}};

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_slot;
   logic [6:0]    r_shadow [6];
   logic          r_colon;

   logic [6:0]    r_seg;
   logic          r_dp;
   logic [5:0]    r_an;
   logic          r_frame;

   logic          w_capture;
   logic          w_blank;
   logic          w_colonSlot;
   logic [6:0]    w_curCode;
   logic [5:0]    w_anSel;

   // A capture happens only at the very first cycle of a scan, so codes
   // never change part way through a frame.
   assign w_capture   = bus.en && (r_cnt == '0) && (r_slot == 3'd0);
   assign w_blank     = !bus.en || (r_cnt < BLANK_END);
   assign w_colonSlot = (r_slot == 3'd2) || (r_slot == 3'd4);
   assign w_anSel     = ~(6'b000001 << r_slot);

   // Select the held code for the slot currently being scanned; slot values
   // 6 and 7 never occur, the default only keeps the mux fully specified.
   always_comb begin
      w_curCode = 7'h00;
      case (r_slot)
         3'd0:    w_curCode = r_shadow[0];
         3'd1:    w_curCode = r_shadow[1];
         3'd2:    w_curCode = r_shadow[2];
         3'd3:    w_curCode = r_shadow[3];
         3'd4:    w_curCode = r_shadow[4];
         3'd5:    w_curCode = r_shadow[5];
         default: w_curCode = 7'h00;
      endcase
   end

   // Scan position, shadow capture, colon flag and the registered pin
   // outputs. The outputs are decoded from the state as it stands before
   // this edge, giving a uniform one-cycle latency for an/seg/dp/frame.
   // The colon toggles on tick regardless of en; reset overrides all.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_slot  <= 3'd0;
         r_colon <= 1'b1;
         for (int k = 0; k < 6; k++) begin
            r_shadow[k] <= 7'h00;
         end
         r_an    <= 6'b111111;
         r_seg   <= SEG_POL;
         r_dp    <= SEG_ACT_LOW;
         r_frame <= 1'b0;
      end else begin
         if (bus.tick) begin
            r_colon <= ~r_colon;
         end

         if (bus.en) begin
            if (r_cnt == CNT_LAST) begin
               r_cnt  <= '0;
               r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
            end else begin
               r_cnt  <= r_cnt + 1'b1;
            end
         end

         if (w_capture) begin
            r_shadow[0] <= bus.s_l;
            r_shadow[1] <= bus.s_m;
            r_shadow[2] <= bus.m_l;
            r_shadow[3] <= bus.m_m;
            r_shadow[4] <= bus.h_l;
            r_shadow[5] <= bus.h_m;
         end

         r_frame <= w_capture;

         if (w_blank) begin
            r_an  <= 6'b111111;
            r_seg <= SEG_POL;
            r_dp  <= SEG_ACT_LOW;
         end else begin
            r_an  <= w_anSel;
            r_seg <= w_curCode ^ SEG_POL;
            r_dp  <= (r_colon && w_colonSlot) ^ SEG_ACT_LOW;
         end
      end
   end

   assign bus.an    = r_an;
   assign bus.seg   = r_seg;
   assign bus.dp    = r_dp;
   assign bus.frame = r_frame;

endmodule

// File: tb/tb_rtc_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_rtc_disp_scan
// Self-checking bench for rtc_disp_scan with DIV=4, BLANK=1. A behavioural
// model tracks the scan as a single position within the 6*DIV-cycle frame
// and predicts every registered output; a compare process checks the DUT
// against it on every falling edge. Directed sequences pin literal values,
// then a randomized phase exercises en, tick, code changes and resets.
// ---------------------------------------------------------------------------
module tb_rtc_disp_scan;

   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int FRAME = 6 * DIV;

   logic clk;
   logic rst;

   rtc_disp_scan_if bus ();

   rtc_disp_scan #(
      .DIV         (DIV),
      .BLANK       (BLANK),
      .SEG_ACT_LOW (1'b0)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int assertCount = 0;
   int failCount   = 0;

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual %0h required %0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: mPos is the cycle index within the frame.
   // ------------------------------------------------------------------
   int         mPos;
   logic       mColon;
   logic [6:0] mShadow [6];
   logic [5:0] expAn;
   logic [6:0] expSeg;
   logic       expDp;
   logic       expFrame;
   bit         modelValid = 1'b0;

   function automatic logic [6:0] inputCode(input int k);
      case (k)
         0:       return bus.s_l;
         1:       return bus.s_m;
         2:       return bus.m_l;
         3:       return bus.m_m;
         4:       return bus.h_l;
         default: return bus.h_m;
      endcase
   endfunction

   // The model advances at each rising edge using the values the DUT saw.
   initial begin
      int  slot;
      int  phase;
      bit  blank;
      bit  cap;
      forever begin
         @(posedge clk);
         if (rst) begin
            mPos     = 0;
            mColon   = 1'b1;
            for (int k = 0; k < 6; k++) mShadow[k] = 7'h00;
            expAn    = 6'b111111;
            expSeg   = 7'h00;
            expDp    = 1'b0;
            expFrame = 1'b0;
         end else begin
            slot     = mPos / DIV;
            phase    = mPos % DIV;
            cap      = bus.en && (mPos == 0);
            blank    = !bus.en || (phase < BLANK);
            expAn    = blank ? 6'b111111 : ~(6'd1 << slot);
            expSeg   = blank ? 7'h00 : mShadow[slot];
            expDp    = !blank && (slot == 2 || slot == 4) && mColon;
            expFrame = cap;
            if (cap) begin
               for (int k = 0; k < 6; k++) mShadow[k] = inputCode(k);
            end
            if (bus.tick) mColon = !mColon;
            if (bus.en) mPos = (mPos + 1) % FRAME;
         end
         modelValid = 1'b1;
      end
   end

   // Compare DUT outputs against the model away from the active edge.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("an",    bus.an,    expAn);
         checkOutput("seg",   bus.seg,   expSeg);
         checkOutput("dp",    bus.dp,    expDp);
         checkOutput("frame", bus.frame, expFrame);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic setCodes(input logic [6:0] c0, input logic [6:0] c1,
                           input logic [6:0] c2, input logic [6:0] c3,
                           input logic [6:0] c4, input logic [6:0] c5);
      bus.s_l = c0;
      bus.s_m = c1;
      bus.m_l = c2;
      bus.m_m = c3;
      bus.h_l = c4;
      bus.h_m = c5;
   endtask

   task automatic stepUntilAn(input logic [5:0] target, output int steps);
      steps = 0;
      do begin
         step();
         steps++;
      end while (bus.an !== target && steps < 200);
      checkOutput("reachAn", bus.an, target);
   endtask

   task automatic waitFrame(output int steps);
      steps = 0;
      do begin
         step();
         steps++;
      end while (bus.frame !== 1'b1 && steps < 200);
      checkOutput("reachFrame", bus.frame, 1'b1);
   endtask

   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         rst     = ($urandom_range(0, 399) == 0);
         bus.en  = ($urandom_range(0, 15) != 0);
         bus.tick = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) begin
            setCodes(7'($urandom), 7'($urandom), 7'($urandom),
                     7'($urandom), 7'($urandom), 7'($urandom));
         end
         step();
      end
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      int n;
      int total;

      rst      = 1'b1;
      bus.en   = 1'b1;
      bus.tick = 1'b0;
      setCodes(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D);

      // Reset held three cycles with tick toggling.
      repeat (3) begin
         step();
         checkOutput("rstAn",    bus.an,    6'b111111);
         checkOutput("rstSeg",   bus.seg,   7'h00);
         checkOutput("rstDp",    bus.dp,    1'b0);
         checkOutput("rstFrame", bus.frame, 1'b0);
         bus.tick = ~bus.tick;
      end
      bus.tick = 1'b0;
      rst      = 1'b0;

      // First edge after release captures; output blank with frame pulse.
      step();
      checkOutput("firstFrame", bus.frame, 1'b1);
      checkOutput("firstBlank", bus.an,    6'b111111);
      step();
      checkOutput("slot0An",  bus.an,  6'b111110);
      checkOutput("slot0Seg", bus.seg, 7'h06);
      repeat (4) step();
      checkOutput("slot1An",  bus.an,  6'b111101);
      checkOutput("slot1Seg", bus.seg, 7'h5B);
      repeat (4) step();
      checkOutput("slot2An",  bus.an,  6'b111011);
      checkOutput("slot2Seg", bus.seg, 7'h4F);
      checkOutput("slot2Dp",  bus.dp,  1'b1);
      repeat (15) step();
      checkOutput("framePeriod", bus.frame, 1'b1);

      // No tearing: new codes during slot 3 only appear next frame.
      stepUntilAn(6'b110111, n);
      setCodes(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
      stepUntilAn(6'b101111, n);
      checkOutput("tearSlot4", bus.seg, 7'h6D);
      stepUntilAn(6'b011111, n);
      checkOutput("tearSlot5", bus.seg, 7'h7D);
      waitFrame(n);
      stepUntilAn(6'b111110, n);
      checkOutput("newSlot0", bus.seg, 7'h3F);

      // Enable gating: 10 cycles with en low in mid slot 2.
      waitFrame(n);
      total = 0;
      stepUntilAn(6'b111011, n);
      total += n;
      bus.en = 1'b0;
      step();
      checkOutput("gateBlank", bus.an, 6'b111111);
      repeat (9) step();
      total += 10;
      bus.en = 1'b1;
      step();
      checkOutput("gateResume", bus.an, 6'b111011);
      total += 1;
      waitFrame(n);
      total += n;
      checkOutput("gatePeriod", total, FRAME + 10);

      // Colon: one tick clears it, a second tick lights it again.
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      waitFrame(n);
      stepUntilAn(6'b111011, n);
      checkOutput("colonOff2", bus.dp, 1'b0);
      stepUntilAn(6'b101111, n);
      checkOutput("colonOff4", bus.dp, 1'b0);
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      waitFrame(n);
      stepUntilAn(6'b101111, n);
      checkOutput("colonOn4", bus.dp, 1'b1);

      // Reset mid slot 4 with the colon cleared.
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      waitFrame(n);
      stepUntilAn(6'b101111, n);
      checkOutput("preRstDp", bus.dp, 1'b0);
      rst = 1'b1;
      step();
      checkOutput("midRstAn",  bus.an,  6'b111111);
      checkOutput("midRstSeg", bus.seg, 7'h00);
      rst = 1'b0;
      step();
      checkOutput("postRstFrame", bus.frame, 1'b1);
      stepUntilAn(6'b111011, n);
      checkOutput("postRstColon", bus.dp, 1'b1);

      // Randomized phase checked by the model.
      applyStimulus(3000);
      rst      = 1'b0;
      bus.en   = 1'b1;
      bus.tick = 1'b0;
      repeat (30) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rtc_disp_scan.md
# rtc_disp_scan

Time-multiplexed display driver for the real-time clock's six 7-segment digits. It takes the six per-digit segment codes produced by the clock's BCD-to-segment encoders and drives them onto one shared segment bus with six active-low digit enables. A programmable per-digit dwell time and an inter-digit blanking window suppress ghosting. Segment codes are captured once per full scan, so a display frame never mixes two different times. It sits between the clock core and the board pins, replacing six dedicated 7-bit outputs with 7+1+6 pins.

## Interface
- DIV, 50000, clk cycles per digit slot; legal range 2..2^20.
- BLANK, 500, cycles of blanking at the start of each slot; legal range 1..DIV-1.
- SEG_ACT_LOW, 0, when 1, `seg` and `dp` are inverted at the output register; all values in this document are given for 0.
- clk, input, 1, single system clock; every register is clocked on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, scan enable.
- tick, input, 1, one-cycle pulse per second that toggles the colon.
- s_l, s_m, m_l, m_m, h_l, h_m, input, 7 each, segment codes; active-high, bit 1 lights a segment; bit order is passed through unchanged.
- seg, output, 7, shared segment bus.
- dp, output, 1, colon/decimal-point segment.
- an, output, 6, active-low one-hot digit enable; an[k] selects slot k.
- frame, output, 1, one-cycle pulse marking the start of a scan.

## Operation
- Slot order:
  - slot 0 = s_l
  - slot 1 = s_m
  - slot 2 = m_l
  - slot 3 = m_m
  - slot 4 = h_l
  - slot 5 = h_m
- State:
  - `cnt` runs 0..DIV-1.
  - `slot` runs 0..5.
  - `shadow` holds six 7-bit codes.
  - `colon` is a 1-bit flag.
- Advance rule, when en=1:
  - `cnt` increments each cycle.
  - At cnt=DIV-1, `cnt` wraps to 0 and `slot` increments; slot 5 wraps to 0.
- When en=0, `cnt` and `slot` hold their values.
- Shadow capture: in any cycle with en=1, cnt=0 and slot=0, all six inputs are copied into `shadow`. Inputs are ignored at all other times.
- Output decode, computed from the state in cycle t and registered into cycle t+1:
  - Blank when en=0 or cnt<BLANK: an=6'b111111, seg=7'h00, dp=0.
  - Otherwise: an has bit `slot` at 0 and all other bits at 1; seg=shadow[slot].
  - dp = colon when slot is 2 or 4; otherwise 0.
- frame is 1 in cycle t+1 exactly when a shadow capture occurs in cycle t.
- Colon:
  - `colon` toggles on every cycle with tick=1, independent of en.
  - Reset value is 1, so the colon is lit.
- Reset (rst=1 at a rising edge):
  - cnt=0, slot=0, colon=1.
  - shadow is cleared to all 7'h00.
  - Outputs: an=6'b111111, seg=7'h00, dp=0, frame=0.
  - This applies equally in the middle of a slot or frame; the scan restarts at slot 0, cnt 0.
- Simultaneous events:
  - rst dominates en and tick.
  - tick during a capture cycle toggles `colon` normally.
  - When en rises with the state at cnt=0, slot=0, the capture happens in that same cycle.
- Inputs are assumed synchronous to clk; no synchronizers are included.

## Timing
- Output latency is 1 cycle from the state registers, for all of `an`, `seg`, `dp` and `frame`.
- First cycle after reset release with en=1:
  - State is cnt=0, slot=0, so a capture occurs.
  - In the next cycle, frame=1 and outputs are blank, because cnt=0 < BLANK.
- Each slot lasts DIV cycles:
  - The first BLANK cycles are blank.
  - The remaining DIV-BLANK cycles drive the digit.
- A full scan lasts 6*DIV cycles. The frame period is exactly 6*DIV cycles while en is held at 1.
- Input changes reach the display at the next capture, with worst-case delay 6*DIV+1 cycles.
- An `an` output never has more than one bit low in any cycle.

## Test plan
- Reset: hold rst for 3 cycles with en=1 and tick toggling -> an=6'b111111, seg=0, dp=0, frame=0 throughout reset.
- Full scan with DIV=4, BLANK=1, inputs s_l=7'h06, s_m=7'h5B, m_l=7'h4F, m_m=7'h66, h_l=7'h6D, h_m=7'h7D, en=1 -> frame pulses every 24 cycles. Each 4-cycle slot shows 1 blank cycle, then 3 cycles of an = ~(1<<k) with seg equal to the matching code, in order slot 0..5.
- No tearing: change all inputs to 7'h3F during slot 3 -> slots 3..5 still show the old codes; the new codes appear only from the next frame's slot 0.
- Enable gating: drop en for 10 cycles in mid-slot 2 -> an=6'b111111 from the next cycle; on re-enable, slot 2 resumes at the held cnt; frame timing shifts by exactly 10 cycles.
- Colon: pulse tick once -> dp=0 during slots 2 and 4 from then on. Pulse tick again -> dp=1 during slots 2 and 4. dp=0 in every other slot and in every blank cycle.
- Reset mid-operation: assert rst during slot 4 with colon=0 -> the next frame starts at slot 0, cnt 0. Shadow holds 7'h00 until the first capture, and colon is 1 again.
